// File: rtl/gppcu_seq_pkg.sv
// gppcu_seq_pkg: shared types and sizing for the GPPCU kernel sequencer.
package gppcu_seq_pkg;
   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DRAIN,
      DONE
   } seqState_t;

   localparam int FIFO_DEPTH = 2;
   localparam int FIFO_CNT_W = $clog2(FIFO_DEPTH + 1);
   localparam int PERF_W     = 32;
endpackage

// File: rtl/gppcu_kernel_sequencer_if.sv
// gppcu_kernel_sequencer_if: instruction RAM read port and core instruction stream.
interface gppcu_kernel_sequencer_if #(
   parameter int DBW  = 32,
   parameter int IABW = 10
);
   logic [IABW-1:0] oIMEM_ADDR;
   logic            oIMEM_RD;
   logic [DBW-1:0]  iIMEM_RDATA;
   logic [DBW-1:0]  oINSTR;
   logic            oINSTR_VALID;
   logic            iINSTR_READY;

   modport master (
      output oIMEM_ADDR, oIMEM_RD, oINSTR, oINSTR_VALID,
      input  iIMEM_RDATA, iINSTR_READY
   );

   modport slave (
      input  oIMEM_ADDR, oIMEM_RD, oINSTR, oINSTR_VALID,
      output iIMEM_RDATA, iINSTR_READY
   );
endinterface

// File: rtl/gppcu_seq_prefetch_fifo.sv
// gppcu_seq_prefetch_fifo: 2-entry prefetch buffer; flush wins over push.
module gppcu_seq_prefetch_fifo
   import gppcu_seq_pkg::*;
#(
   parameter int DBW = 32
) (
   input  logic                  iACLK,
   input  logic                  iRST,
   input  logic                  push,
   input  logic [DBW-1:0]        pushData,
   input  logic                  pop,
   input  logic                  flush,
   output logic [DBW-1:0]        head,
   output logic [FIFO_CNT_W-1:0] count
);
   logic [DBW-1:0] mem [FIFO_DEPTH];
   logic           rdPtr;
   logic           wrPtr;

   assign head = mem[rdPtr];

   always_ff @(posedge iACLK or posedge iRST) begin
      if (iRST) begin
         for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
         rdPtr <= 1'b0;
         wrPtr <= 1'b0;
         count <= '0;
      end else if (flush) begin
         rdPtr <= 1'b0;
         wrPtr <= 1'b0;
         count <= '0;
      end else begin
         if (push) begin
            mem[wrPtr] <= pushData;
            wrPtr      <= ~wrPtr;
         end
         if (pop) rdPtr <= ~rdPtr;
         count <= count + FIFO_CNT_W'(push) - FIFO_CNT_W'(pop);
      end
   end
endmodule

// File: rtl/gppcu_kernel_sequencer.sv
// gppcu_kernel_sequencer: streams a kernel from instruction RAM into the core.
// Define GPPCU_SEQ_PERF_EN to add the oSTALL_CYCLES stall counter output.
module gppcu_kernel_sequencer
   import gppcu_seq_pkg::*;
#(
   parameter int DBW          = 32,
   parameter int IABW         = 10,
   parameter int DRAIN_CYCLES = 4
) (
   input  logic              iACLK,
   input  logic              iRST,
   input  logic              iSTART,
   input  logic [IABW-1:0]   iSTART_ADDR,
   input  logic [IABW-1:0]   iINSTR_COUNT,
   input  logic              iABORT,
   output logic              oBUSY,
   output logic              oDONE,
`ifdef GPPCU_SEQ_PERF_EN
   output logic [PERF_W-1:0] oSTALL_CYCLES,
`endif
   gppcu_kernel_sequencer_if.master bus
);
   localparam int DW = $clog2(DRAIN_CYCLES + 1);

   seqState_t             state;
   logic [IABW-1:0]       addr;
   logic [IABW-1:0]       count;
   logic [IABW-1:0]       fetched;
   logic [IABW-1:0]       issued;
   logic [IABW-1:0]       issuedNext;
   logic                  inflight;
   logic [DW-1:0]         drainCnt;
   logic [FIFO_CNT_W-1:0] fifoCnt;
   logic [FIFO_CNT_W:0]   occ;
   logic [DBW-1:0]        head;
   logic                  run;
   logic                  pop;
   logic                  rd;

   assign run        = state == RUN;
   assign pop        = bus.oINSTR_VALID & bus.iINSTR_READY;
   assign issuedNext = issued + IABW'(pop);

   // Crediting this cycle's pop lets reads issue every cycle under ready=1.
   assign occ = {1'b0, fifoCnt}
              + {{FIFO_CNT_W{1'b0}}, inflight}
              - {{FIFO_CNT_W{1'b0}}, pop};
   assign rd  = run & ~iABORT & (fetched < count)
              & (occ < (FIFO_CNT_W + 1)'(FIFO_DEPTH));

   assign bus.oIMEM_ADDR   = addr;
   assign bus.oIMEM_RD     = rd;
   assign bus.oINSTR_VALID = run & (fifoCnt != '0);
   assign bus.oINSTR       = head;

   gppcu_seq_prefetch_fifo #(.DBW(DBW)) uFifo (
      .iACLK    (iACLK),
      .iRST     (iRST),
      .push     (run & inflight),
      .pushData (bus.iIMEM_RDATA),
      .pop      (pop),
      .flush    (run & iABORT),
      .head     (head),
      .count    (fifoCnt)
   );

   always_ff @(posedge iACLK or posedge iRST) begin
      if (iRST) begin
         state    <= IDLE;
         oBUSY    <= 1'b0;
         oDONE    <= 1'b0;
         addr     <= '0;
         count    <= '0;
         fetched  <= '0;
         issued   <= '0;
         inflight <= 1'b0;
         drainCnt <= '0;
      end else begin
         oDONE <= 1'b0;
         unique case (state)
            IDLE: if (iSTART) begin
               addr     <= iSTART_ADDR;
               count    <= iINSTR_COUNT;
               fetched  <= '0;
               issued   <= '0;
               drainCnt <= '0;
               oBUSY    <= 1'b1;
               state    <= (iINSTR_COUNT == '0) ? DRAIN : RUN;
            end
            RUN: begin
               if (rd) begin
                  addr    <= addr + 1'b1;
                  fetched <= fetched + 1'b1;
               end
               inflight <= rd;
               issued   <= issuedNext;
               if (iABORT || issuedNext == count) begin
                  drainCnt <= '0;
                  state    <= DRAIN;
               end
            end
            DRAIN: begin
               if (drainCnt == DW'(DRAIN_CYCLES - 1)) begin
                  oDONE <= 1'b1;
                  state <= DONE;
               end else begin
                  drainCnt <= drainCnt + 1'b1;
               end
            end
            DONE: begin
               oBUSY <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef GPPCU_SEQ_PERF_EN
   always_ff @(posedge iACLK or posedge iRST) begin
      if (iRST) begin
         oSTALL_CYCLES <= '0;
      end else if (state == IDLE && iSTART) begin
         oSTALL_CYCLES <= '0;
      end else if (bus.oINSTR_VALID && !bus.iINSTR_READY
                   && oSTALL_CYCLES != '1) begin
         oSTALL_CYCLES <= oSTALL_CYCLES + 1'b1;
      end
   end
`endif
endmodule

// File: tb/tb_gppcu_kernel_sequencer.sv
// tb_gppcu_kernel_sequencer: randomized kernels checked against address/data/timing rules.
module tb_gppcu_kernel_sequencer;
   localparam int DBW   = 32;
   localparam int IABW  = 10;
   localparam int DRAIN = 4;

   logic            clk = 1'b0;
   logic            iRST;
   logic            iSTART;
   logic [IABW-1:0] iSTART_ADDR;
   logic [IABW-1:0] iINSTR_COUNT;
   logic            iABORT;
   logic            oBUSY;
   logic            oDONE;
`ifdef GPPCU_SEQ_PERF_EN
   logic [31:0]     oSTALL_CYCLES;
`endif
   logic [DBW-1:0]  mem [1 << IABW];
   int              checks = 0;
   int              errors = 0;

   gppcu_kernel_sequencer_if #(.DBW(DBW), .IABW(IABW)) bus ();

   gppcu_kernel_sequencer #(
      .DBW(DBW), .IABW(IABW), .DRAIN_CYCLES(DRAIN)
   ) dut (
      .iACLK        (clk),
      .iRST         (iRST),
      .iSTART       (iSTART),
      .iSTART_ADDR  (iSTART_ADDR),
      .iINSTR_COUNT (iINSTR_COUNT),
      .iABORT       (iABORT),
      .oBUSY        (oBUSY),
      .oDONE        (oDONE),
`ifdef GPPCU_SEQ_PERF_EN
      .oSTALL_CYCLES(oSTALL_CYCLES),
`endif
      .bus          (bus)
   );

   always #5 clk = ~clk;

   // Synchronous RAM: data one cycle after the strobe, garbage otherwise.
   always @(posedge clk)
      bus.iIMEM_RDATA <= bus.oIMEM_RD ? mem[bus.oIMEM_ADDR] : $urandom;

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   // Cycle k below is the cycle that begins k-1 edges after the start edge.
   task automatic runKernel(input logic [IABW-1:0] sa, input int cnt,
                            input int mode, input int abortAt,
                            input int restartAt);
      int reads = 0, xfers = 0, firstValid = -1, lastXfer = -1;
      int doneAt = -1, busyCyc = 0, stalls = 0, dones = 0;
      int maxOut = 0, abortCyc = -1, lateReads = 0;
      logic [DBW-1:0]  held = '0;
      logic            heldV = 1'b0;
      logic            rdy;
      logic [IABW-1:0] ea;
      @(negedge clk);
      iSTART       = 1'b1;
      iSTART_ADDR  = sa;
      iINSTR_COUNT = IABW'(cnt);
      @(negedge clk);
      for (int cyc = 1; cyc < 400 && doneAt < 0; cyc++) begin
         case (mode)
            0:       rdy = 1'b1;
            1:       rdy = (cyc % 3) == 1;
            default: rdy = 1'($urandom_range(0, 1));
         endcase
         iABORT = 1'b0;
         if (abortAt >= 0 && abortCyc < 0 && xfers == abortAt) begin
            abortCyc = cyc;
            iABORT   = 1'b1;
            rdy      = 1'b0;
         end
         iSTART       = cyc == restartAt;
         iSTART_ADDR  = sa + 10'd100;
         iINSTR_COUNT = 10'd3;
         bus.iINSTR_READY = rdy;
         #1;
         if (bus.oIMEM_RD) begin
            ea = sa + IABW'(reads);
            chk("rdaddr", 64'(bus.oIMEM_ADDR), 64'(ea));
            reads++;
            if (abortCyc >= 0) lateReads++;
         end
         if (heldV)
            chk("hold", {bus.oINSTR_VALID, bus.oINSTR}, {1'b1, held});
         if (abortCyc >= 0 && cyc == abortCyc + 1)
            chk("abortvalid", 64'(bus.oINSTR_VALID), 64'd0);
         if (bus.oINSTR_VALID && firstValid < 0) firstValid = cyc;
         if (bus.oINSTR_VALID && rdy) begin
            ea = sa + IABW'(xfers);
            chk("data", 64'(bus.oINSTR), 64'(mem[ea]));
            xfers++;
            lastXfer = cyc;
         end
         if (bus.oINSTR_VALID && !rdy) stalls++;
         if (reads - xfers > maxOut) maxOut = reads - xfers;
         if (oBUSY) busyCyc++;
         if (oDONE) begin
            dones++;
            doneAt = cyc;
         end
         heldV = bus.oINSTR_VALID && !rdy && cyc != abortCyc;
         held  = bus.oINSTR;
         @(negedge clk);
      end
      iSTART = 1'b0;
      iABORT = 1'b0;
      #1;
      chk("timeout", 64'(doneAt >= 0), 64'd1);
      chk("idle", {oBUSY, oDONE}, 64'd0);
      chk("dones", 64'(dones), 64'd1);
      chk("busy", 64'(busyCyc), 64'(doneAt));
      chk("maxout", 64'(maxOut <= 2), 64'd1);
      if (abortAt >= 0) begin
         chk("abortxfers", 64'(xfers), 64'(abortAt));
         chk("latereads", 64'(lateReads), 64'd0);
         chk("abortdone", 64'(doneAt - abortCyc), 64'(DRAIN + 1));
      end else begin
         chk("xfers", 64'(xfers), 64'(cnt));
         chk("reads", 64'(reads), 64'(cnt));
         if (cnt > 0) begin
            chk("latency", 64'(firstValid - 1), 64'd2);
            chk("drain", 64'(doneAt - lastXfer), 64'(DRAIN + 1));
            if (mode == 0)
               chk("stream", 64'(lastXfer - firstValid), 64'(cnt - 1));
         end
      end
`ifdef GPPCU_SEQ_PERF_EN
      chk("stalls", 64'(oSTALL_CYCLES), 64'(stalls));
`endif
   endtask

   task automatic midReset();
      @(negedge clk);
      iSTART           = 1'b1;
      iSTART_ADDR      = 10'h080;
      iINSTR_COUNT     = 10'd8;
      bus.iINSTR_READY = 1'b0;
      @(negedge clk);
      iSTART = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      chk("prerst", {oBUSY, bus.oINSTR_VALID}, 64'd3);
      #1 iRST = 1'b1;
      #1;
      chk("rstout", {oBUSY, oDONE, bus.oIMEM_RD, bus.oINSTR_VALID,
                     bus.oIMEM_ADDR, bus.oINSTR}, 64'd0);
`ifdef GPPCU_SEQ_PERF_EN
      chk("rststall", 64'(oSTALL_CYCLES), 64'd0);
`endif
      @(negedge clk);
      iRST = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < (1 << IABW); i++) mem[i] = $urandom;
      iRST             = 1'b1;
      iSTART           = 1'b0;
      iSTART_ADDR      = '0;
      iINSTR_COUNT     = '0;
      iABORT           = 1'b0;
      bus.iINSTR_READY = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      chk("reset", {oBUSY, oDONE, bus.oIMEM_RD, bus.oINSTR_VALID,
                    bus.oIMEM_ADDR, bus.oINSTR}, 64'd0);
      iRST = 1'b0;
      runKernel(10'h010, 5, 0, -1, -1);
      runKernel(10'h020, 5, 1, -1, -1);
      runKernel(10'h3FE, 4, 0, -1, -1);
      runKernel(10'h100, 0, 0, -1, 2);
      runKernel(10'h200, 8, 0, 2, -1);
      runKernel(10'h040, 6, 0, -1, -1);
      midReset();
      runKernel(10'h300, 6, 2, -1, 4);
      for (int k = 0; k < 8; k++)
         runKernel(IABW'($urandom), int'($urandom_range(1, 12)), 2, -1, -1);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
